// File: rtl/datapath_pipe.sv
// datapath_pipe: three-stage EX/MEM/WB datapath with a register file,
// a word-addressed data memory, operand forwarding and load-use stall.
// Ports: clock, reset (async, active-high); in_valid/in_ready handshake
// for the control word SA, SB, DA, RegWrite, MemWrite, FS, SD, Bsel,
// Const; data/wb_valid show the WB value; status is {V,C,N,Z}.
module datapath_pipe #(
    parameter int WIDTH     = 64,
    parameter int NREG      = 32,
    parameter int MEM_DEPTH = 256
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [$clog2(NREG)-1:0] SA,
    input  logic [$clog2(NREG)-1:0] SB,
    input  logic [$clog2(NREG)-1:0] DA,
    input  logic                    RegWrite,
    input  logic                    MemWrite,
    input  logic [4:0]              FS,
    input  logic                    SD,
    input  logic                    Bsel,
    input  logic [WIDTH-1:0]        Const,
    output logic [WIDTH-1:0]        data,
    output logic                    wb_valid,
    output logic [3:0]              status
);

    localparam int RW = $clog2(NREG);
    localparam int AW = $clog2(MEM_DEPTH);
    localparam logic [RW-1:0] ZR = RW'(NREG - 1);

    typedef struct packed {
        logic             valid;
        logic [RW-1:0]    sa;
        logic [RW-1:0]    sb;
        logic [RW-1:0]    da;
        logic             reg_write;
        logic             mem_write;
        logic [4:0]       fs;
        logic             sd;
        logic             bsel;
        logic [WIDTH-1:0] imm;
    } ex_t;

    typedef struct packed {
        logic             valid;
        logic [RW-1:0]    da;
        logic             reg_write;
        logic             mem_write;
        logic             sd;
        logic [WIDTH-1:0] alu;
        logic [WIDTH-1:0] st;
    } mem_t;

    typedef struct packed {
        logic             valid;
        logic [RW-1:0]    da;
        logic             reg_write;
        logic             sd;
        logic [WIDTH-1:0] alu;
    } wb_t;

    ex_t              ex_q;
    ex_t              ex_d;
    mem_t             mem_q;
    mem_t             mem_d;
    wb_t              wb_q;
    wb_t              wb_d;
    logic [3:0]       status_q;
    logic [3:0]       status_d;

    logic [WIDTH-1:0] rf_q [NREG];
    logic [WIDTH-1:0] ram [MEM_DEPTH];
    logic [WIDTH-1:0] ram_rd_q;

    logic             mem_fwd;
    logic             wb_fwd;
    logic [WIDTH-1:0] rf_a;
    logic [WIDTH-1:0] rf_b;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [WIDTH-1:0] opnd_b;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_r;
    logic             flag_c;
    logic             flag_v;
    logic [WIDTH-1:0] wb_data;
    logic             load_hit;
    logic             use_b;
    logic             stall;
    logic             rf_we;
    logic             ram_we;
    logic [AW-1:0]    ram_addr;

    // WB value: memory word for loads, ALU result otherwise.
    assign wb_data  = wb_q.sd ? ram_rd_q : wb_q.alu;
    assign data     = wb_q.valid ? wb_data : '0;
    assign wb_valid = wb_q.valid;
    assign status   = status_q;

    // Operand read with forwarding: MEM ALU result, then WB, then file.
    // R[NREG-1] is never a forwarding target.
    always_comb begin
        mem_fwd = mem_q.valid && mem_q.reg_write &&
                  !mem_q.sd && (mem_q.da != ZR);
        wb_fwd  = wb_q.valid && wb_q.reg_write &&
                  (wb_q.da != ZR);
        rf_a    = (ex_q.sa == ZR) ? '0 : rf_q[ex_q.sa];
        rf_b    = (ex_q.sb == ZR) ? '0 : rf_q[ex_q.sb];

        if (mem_fwd && (mem_q.da == ex_q.sa)) begin
            src_a = mem_q.alu;
        end else if (wb_fwd && (wb_q.da == ex_q.sa)) begin
            src_a = wb_data;
        end else begin
            src_a = rf_a;
        end

        if (mem_fwd && (mem_q.da == ex_q.sb)) begin
            src_b = mem_q.alu;
        end else if (wb_fwd && (wb_q.da == ex_q.sb)) begin
            src_b = wb_data;
        end else begin
            src_b = rf_b;
        end

        opnd_b = ex_q.bsel ? ex_q.imm : src_b;
    end

    // ALU. FS[0] doubles as the adder carry-in so that
    // FS = ADD with inverted B gives A - B.
    always_comb begin
        op_a   = ex_q.fs[1] ? ~src_a : src_a;
        op_b   = ex_q.fs[0] ? ~opnd_b : opnd_b;
        sum    = {1'b0, op_a} + {1'b0, op_b} +
                 {{WIDTH{1'b0}}, ex_q.fs[0]};
        alu_r  = '0;
        flag_c = 1'b0;
        flag_v = 1'b0;
        unique case (ex_q.fs[4:2])
            3'b000: alu_r = op_a & op_b;
            3'b001: alu_r = op_a | op_b;
            3'b010: begin
                alu_r  = sum[WIDTH-1:0];
                flag_c = sum[WIDTH];
                flag_v = (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                         (alu_r[WIDTH-1] != op_a[WIDTH-1]);
            end
            3'b011: alu_r = op_a ^ op_b;
            3'b100: alu_r = op_a << op_b[5:0];
            3'b101: alu_r = op_a >> op_b[5:0];
            default: alu_r = '0;
        endcase
    end

    // Load-use: a load in MEM cannot forward its data until WB, so the
    // dependent op waits one cycle in EX. Loads to R[NREG-1] never
    // create a dependency.
    always_comb begin
        use_b    = !ex_q.bsel || ex_q.mem_write;
        load_hit = mem_q.valid && mem_q.reg_write &&
                   mem_q.sd && (mem_q.da != ZR);
        stall    = ex_q.valid && load_hit &&
                   ((mem_q.da == ex_q.sa) ||
                    (use_b && (mem_q.da == ex_q.sb)));
        in_ready = !reset && !stall;
    end

    always_comb begin
        ex_d = ex_q;
        if (!stall) begin
            ex_d.valid     = in_valid;
            ex_d.sa        = SA;
            ex_d.sb        = SB;
            ex_d.da        = DA;
            ex_d.reg_write = RegWrite;
            ex_d.mem_write = MemWrite;
            ex_d.fs        = FS;
            ex_d.sd        = SD;
            ex_d.bsel      = Bsel;
            ex_d.imm       = Const;
        end

        mem_d = '0;
        if (!stall) begin
            mem_d.valid     = ex_q.valid;
            mem_d.da        = ex_q.da;
            mem_d.reg_write = ex_q.reg_write;
            mem_d.mem_write = ex_q.mem_write;
            mem_d.sd        = ex_q.sd;
            mem_d.alu       = alu_r;
            mem_d.st        = src_b;
        end

        wb_d.valid     = mem_q.valid;
        wb_d.da        = mem_q.da;
        wb_d.reg_write = mem_q.reg_write;
        wb_d.sd        = mem_q.sd;
        wb_d.alu       = mem_q.alu;

        status_d = status_q;
        if (ex_q.valid && !stall) begin
            status_d = {flag_v, flag_c, alu_r[WIDTH-1],
                        (alu_r == '0)};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ex_q     <= '0;
            mem_q    <= '0;
            wb_q     <= '0;
            status_q <= '0;
        end else begin
            ex_q     <= ex_d;
            mem_q    <= mem_d;
            wb_q     <= wb_d;
            status_q <= status_d;
        end
    end

    assign rf_we = wb_q.valid && wb_q.reg_write && (wb_q.da != ZR);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else if (rf_we) begin
            rf_q[wb_q.da] <= wb_data;
        end
    end

    // Memory is not reset; upper address bits wrap.
    assign ram_we   = mem_q.valid && mem_q.mem_write;
    assign ram_addr = mem_q.alu[AW-1:0];

    always_ff @(posedge clock) begin
        if (ram_we) begin
            ram[ram_addr] <= mem_q.st;
        end
        ram_rd_q <= ram[ram_addr];
    end

endmodule

// File: tb/tb_datapath_pipe.sv
// tb_datapath_pipe: vector table + scoreboard bench for datapath_pipe.
// Drives control words, checks WB data, stalls, status and reset.
module tb_datapath_pipe;

    localparam int W  = 64;
    localparam int MD = 256;

    localparam logic [4:0] F_AND  = 5'b00000;
    localparam logic [4:0] F_ANDA = 5'b00010;
    localparam logic [4:0] F_OR   = 5'b00100;
    localparam logic [4:0] F_ADD  = 5'b01000;
    localparam logic [4:0] F_SUB  = 5'b01001;
    localparam logic [4:0] F_NEGA = 5'b01010;
    localparam logic [4:0] F_XOR  = 5'b01100;
    localparam logic [4:0] F_SHL  = 5'b10000;
    localparam logic [4:0] F_SHR  = 5'b10100;
    localparam logic [4:0] F_BAD  = 5'b11000;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [4:0]   sa = '0;
    logic [4:0]   sb = '0;
    logic [4:0]   da = '0;
    logic         rw = 1'b0;
    logic         mw = 1'b0;
    logic [4:0]   fs = '0;
    logic         sd = 1'b0;
    logic         bsel = 1'b0;
    logic [W-1:0] imm = '0;
    logic [W-1:0] data;
    logic         wb_valid;
    logic [3:0]   status;

    always #5 clock = ~clock;

    datapath_pipe #(
        .WIDTH(W), .NREG(32), .MEM_DEPTH(MD)
    ) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .SA(sa), .SB(sb), .DA(da),
        .RegWrite(rw), .MemWrite(mw), .FS(fs),
        .SD(sd), .Bsel(bsel), .Const(imm),
        .data(data), .wb_valid(wb_valid), .status(status)
    );

    typedef struct {
        logic [4:0]   sa;
        logic [4:0]   sb;
        logic [4:0]   da;
        logic         rw;
        logic         mw;
        logic [4:0]   fs;
        logic         sd;
        logic         bsel;
        logic [W-1:0] imm;
        logic [W-1:0] exp;
    } vec_t;

    typedef struct {
        int           id;
        logic [W-1:0] val;
    } sb_t;

    vec_t tbl[$];
    sb_t  exp_q[$];
    sb_t  e;
    int   n_chk = 0;
    int   n_pass = 0;
    int   stall_cnt = 0;

    function automatic vec_t mk(
        input int sa_i, input int sb_i, input int da_i,
        input bit rw_i, input bit mw_i, input logic [4:0] fs_i,
        input bit sd_i, input bit bsel_i,
        input logic [W-1:0] imm_i, input logic [W-1:0] exp_i);
        vec_t v;
        v.sa   = 5'(sa_i);
        v.sb   = 5'(sb_i);
        v.da   = 5'(da_i);
        v.rw   = rw_i;
        v.mw   = mw_i;
        v.fs   = fs_i;
        v.sd   = sd_i;
        v.bsel = bsel_i;
        v.imm  = imm_i;
        v.exp  = exp_i;
        return v;
    endfunction

    task automatic chk(input string name,
                       input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h",
                      name, act, exp);
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (in_valid && !in_ready) stall_cnt++;
            if (wb_valid) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL wb_extra: got data %0h expected no output",
                             data);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("wb_data op%0d", e.id), data, e.val);
                end
            end
        end
    end

    task automatic issue(input vec_t v, input int id);
        int n;
        sa = v.sa; sb = v.sb; da = v.da;
        rw = v.rw; mw = v.mw; fs = v.fs;
        sd = v.sd; bsel = v.bsel; imm = v.imm;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        if (!in_ready) begin
            n_chk++;
            $display("FAIL accept op%0d: in_ready 0 expected 1", id);
        end else begin
            exp_q.push_back('{id, v.exp});
        end
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    task automatic run(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) issue(tbl[i], i);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(posedge clock);
            n++;
        end
        @(negedge clock);
        n_chk++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain %s: got %0d pending expected 0",
                      name, exp_q.size());
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // 0: reset-cleared register file
        tbl.push_back(mk(31, 5, 8, 1, 0, F_OR, 0, 0, 0, 0));
        // 1-4: back-to-back forwarding
        tbl.push_back(mk(31, 0, 9, 1, 0, F_AND, 0, 1, 5, 0));
        tbl.push_back(mk(31, 0, 5, 1, 0, F_OR, 0, 1, 24, 24));
        tbl.push_back(mk(31, 0, 7, 1, 0, F_OR, 0, 1, 39, 39));
        tbl.push_back(mk(5, 7, 1, 1, 0, F_ADD, 0, 0, 0, 63));
        // 5-10: chains and remaining ALU ops
        tbl.push_back(mk(1, 5, 30, 1, 0, F_XOR, 0, 0, 0, 39));
        tbl.push_back(mk(30, 0, 17, 1, 0, F_SHL, 0, 1, 2, 156));
        tbl.push_back(mk(17, 30, 18, 1, 0, F_SUB, 0, 0, 0, 117));
        tbl.push_back(mk(1, 0, 19, 1, 0, F_SHR, 0, 1, 1, 31));
        tbl.push_back(mk(31, 0, 20, 1, 0, F_ANDA, 0, 1, 'hF0, 'hF0));
        tbl.push_back(mk(1, 5, 21, 1, 0, F_BAD, 0, 0, 0, 0));
        // 11-21: memory, load-use, wrap
        tbl.push_back(mk(31, 7, 0, 0, 1, F_OR, 0, 1, 4, 4));
        tbl.push_back(mk(31, 1, 0, 0, 1, F_OR, 0, 1, 6, 6));
        tbl.push_back(mk(31, 0, 11, 1, 0, F_OR, 1, 1, 4, 39));
        tbl.push_back(mk(11, 0, 13, 1, 0, F_ADD, 0, 1, 1, 40));
        tbl.push_back(mk(31, 0, 14, 1, 0, F_OR, 1, 1, 6, 63));
        tbl.push_back(mk(31, 13, 0, 0, 1, F_OR, 0, 1, MD + 3, MD + 3));
        tbl.push_back(mk(31, 0, 15, 1, 0, F_OR, 1, 1, 3, 40));
        tbl.push_back(mk(15, 31, 16, 1, 0, F_ADD, 0, 0, 0, 40));
        tbl.push_back(mk(31, 0, 22, 1, 0, F_OR, 1, 1, 4, 39));
        tbl.push_back(mk(31, 22, 0, 0, 1, F_OR, 0, 1, 7, 7));
        tbl.push_back(mk(31, 0, 23, 1, 0, F_OR, 1, 1, 7, 39));
        // 22-26: flags and R31
        tbl.push_back(mk(31, 0, 2, 1, 0, F_OR, 0, 1,
                         64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF));
        tbl.push_back(mk(2, 0, 2, 1, 0, F_ADD, 0, 1, 1,
                         64'h8000_0000_0000_0000));
        tbl.push_back(mk(5, 5, 31, 1, 0, F_ADD, 0, 0, 0, 48));
        tbl.push_back(mk(31, 5, 24, 1, 0, F_ADD, 0, 0, 0, 24));
        tbl.push_back(mk(31, 0, 25, 1, 0, F_NEGA, 0, 1, 1, 0));
        // 27-32: reset with ops in flight
        tbl.push_back(mk(31, 7, 0, 0, 1, F_OR, 0, 1, 8, 8));
        tbl.push_back(mk(31, 0, 26, 1, 0, F_OR, 0, 1, 77, 77));
        tbl.push_back(mk(31, 1, 0, 0, 1, F_OR, 0, 1,
                         64'h8000_0000_0000_0008, 64'h8000_0000_0000_0008));
        tbl.push_back(mk(31, 0, 27, 1, 0, F_OR, 0, 1, 5, 5));
        tbl.push_back(mk(31, 0, 28, 1, 0, F_OR, 1, 1, 8, 39));
        tbl.push_back(mk(31, 7, 29, 1, 0, F_OR, 0, 0, 0, 0));

        #12;
        chk("reset status", W'(status), 0);
        chk("reset data", data, 0);
        chk("reset wb_valid", W'(wb_valid), 0);
        chk("reset in_ready", W'(in_ready), 0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk("idle in_ready", W'(in_ready), 1);

        run(0, 0);
        drain("rf_clear");

        stall_cnt = 0;
        run(1, 4);
        drain("fwd");
        chk("fwd stalls", W'(stall_cnt), 0);
        chk("fwd status", W'(status), 4'b0000);

        run(5, 10);
        drain("chain");
        chk("chain stalls", W'(stall_cnt), 0);
        chk("chain status", W'(status), 4'b0001);

        stall_cnt = 0;
        run(11, 21);
        drain("mem");
        chk("mem stalls", W'(stall_cnt), 3);

        run(22, 23);
        drain("ovf");
        repeat (3) @(negedge clock);
        chk("ovf status", W'(status), 4'b1010);

        run(24, 26);
        drain("r31");
        chk("carry status", W'(status), 4'b0101);

        run(27, 27);
        drain("pre_reset");
        run(28, 30);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst wb_valid", W'(wb_valid), 0);
        chk("midrst data", data, 0);
        chk("midrst status", W'(status), 0);
        chk("midrst in_ready", W'(in_ready), 0);
        exp_q.delete();
        @(posedge clock);
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk("post_rst wb_valid", W'(wb_valid), 0);

        stall_cnt = 0;
        run(31, 32);
        drain("post_rst");
        chk("post_rst stalls", W'(stall_cnt), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
